i2c_bus_arbiter: RTL and testbench

- Round-robin arbiter/sequencer that shares one i2c_basic transaction engine among up to 8 independent requesters (I/O-expander controllers, codec/PLL config blocks).
- Each requester presents a complete transaction descriptor and a level request. The arbiter grants one requester, drives the engine, and returns read data plus a one-cycle ack.
- Sits between the per-device controllers and the single i2c_basic instance on the shared SCL/SDA pins.

---
 rtl/i2c_bus_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sequencer that shares one i2c_basic engine
// among NUM_REQ requesters, each presenting a full transaction descriptor.
// Optional watchdog on the engine wait: define I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [7*NUM_REQ-1:0]  req_addr,
  input  logic [2*NUM_REQ-1:0]  req_num_wr,
  input  logic [24*NUM_REQ-1:0] req_wr_data,
  input  logic [2*NUM_REQ-1:0]  req_num_rd,
  output logic [NUM_REQ-1:0]    ack,
  output logic                  err,
  output logic [15:0]           rd_data,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic [6:0]            i2c_addr,
  output logic [1:0]            i2c_num_wr_bytes,
  output logic [7:0]            i2c_wr_data0,
  output logic [7:0]            i2c_wr_data1,
  output logic [7:0]            i2c_wr_data2,
  output logic [1:0]            i2c_num_rd_bytes,
  output logic                  i2c_start,
  input  logic                  i2c_done,
  input  logic [7:0]            i2c_rd_data0,
  input  logic [7:0]            i2c_rd_data1,
  output logic                  i2c_rst_req
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT   = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_HOLDOFF = 3'd5;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned ADDR_W  = 7 * MAX_REQ;
  localparam int unsigned CNT_W   = 2 * MAX_REQ;
  localparam int unsigned DATA_W  = 24 * MAX_REQ;

  // Elaboration-time guard on the legal parameter range.
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("i2c_bus_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
  end

  logic [2:0]          state;
  logic [2:0]          state_nxt;
  logic [2:0]          rr_ptr;
  logic                any_req_c;
  logic [2:0]          sel_c;
  logic [3:0]          cand_c;
  logic                timeout_hit_c;
  logic [MAX_REQ-1:0]  req_pad;
  logic [ADDR_W-1:0]   addr_pad;
  logic [CNT_W-1:0]    nwr_pad;
  logic [CNT_W-1:0]    nrd_pad;
  logic [DATA_W-1:0]   wdat_pad;
  int unsigned         gi_c;

  // Zero-extend the requester buses to the maximum width so a 3-bit index is always in range.
  assign req_pad  = MAX_REQ'(req);
  assign addr_pad = ADDR_W'(req_addr);
  assign nwr_pad  = CNT_W'(req_num_wr);
  assign nrd_pad  = CNT_W'(req_num_rd);
  assign wdat_pad = DATA_W'(req_wr_data);
  assign gi_c     = 32'(grant_id);

  // Round-robin pick: first set request at or above rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    any_req_c = 1'b0;
    sel_c     = 3'd0;
    cand_c    = 4'd0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand_c = {1'b0, rr_ptr} + 4'(i);
      if (cand_c >= 4'(NUM_REQ)) cand_c = cand_c - 4'(NUM_REQ);
      if (!any_req_c && req_pad[cand_c[2:0]]) begin
        any_req_c = 1'b1;
        sel_c     = cand_c[2:0];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WD_W-1:0] wd_cnt;

  // Watchdog: cleared on the way into WAIT, counts every WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == S_START) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  assign timeout_hit_c = (state == S_WAIT) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (any_req_c) state_nxt = S_GRANT;
      S_GRANT:   state_nxt = S_START;
      S_START:   state_nxt = S_WAIT;
      S_WAIT:    if (i2c_done || timeout_hit_c) state_nxt = S_ACK;
      S_ACK:     state_nxt = S_HOLDOFF;
      S_HOLDOFF: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs: grant capture, descriptor freeze, pulses, read data, rr pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack              <= '0;
      err              <= 1'b0;
      rd_data          <= 16'h0000;
      busy             <= 1'b0;
      grant_id         <= 3'd0;
      i2c_addr         <= 7'h00;
      i2c_num_wr_bytes <= 2'd0;
      i2c_wr_data0     <= 8'h00;
      i2c_wr_data1     <= 8'h00;
      i2c_wr_data2     <= 8'h00;
      i2c_num_rd_bytes <= 2'd0;
      i2c_start        <= 1'b0;
      i2c_rst_req      <= 1'b0;
      rr_ptr           <= 3'd0;
    end else begin
      ack         <= '0;
      i2c_start   <= 1'b0;
      i2c_rst_req <= 1'b0;
      busy        <= (state_nxt != S_IDLE);
      case (state)
        S_IDLE: begin
          if (any_req_c) grant_id <= sel_c;
        end
        S_GRANT: begin
          i2c_addr         <= addr_pad[gi_c*7 +: 7];
          i2c_num_wr_bytes <= nwr_pad[gi_c*2 +: 2];
          i2c_wr_data0     <= wdat_pad[gi_c*24 +: 8];
          i2c_wr_data1     <= wdat_pad[gi_c*24 + 8 +: 8];
          i2c_wr_data2     <= wdat_pad[gi_c*24 + 16 +: 8];
          i2c_num_rd_bytes <= nrd_pad[gi_c*2 +: 2];
          i2c_start        <= 1'b1;
        end
        S_WAIT: begin
          if (i2c_done) begin
            rd_data <= {i2c_rd_data1, i2c_rd_data0};
            err     <= 1'b0;
            ack     <= NUM_REQ'(MAX_REQ'(1) << grant_id);
          end else if (timeout_hit_c) begin
            err         <= 1'b1;
            i2c_rst_req <= 1'b1;
            ack         <= NUM_REQ'(MAX_REQ'(1) << grant_id);
          end
        end
        S_ACK: begin
          rr_ptr <= (grant_id == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed scenarios plus randomized
// transactions predicted by a transaction-level round-robin model.
module tb_i2c_bus_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 16;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req;
  logic [7*NR-1:0] req_addr;
  logic [2*NR-1:0] req_num_wr;
  logic [24*NR-1:0] req_wr_data;
  logic [2*NR-1:0] req_num_rd;
  logic [NR-1:0]   ack;
  logic            err;
  logic [15:0]     rd_data;
  logic            busy;
  logic [2:0]      grant_id;
  logic [6:0]      i2c_addr;
  logic [1:0]      i2c_num_wr_bytes;
  logic [7:0]      i2c_wr_data0;
  logic [7:0]      i2c_wr_data1;
  logic [7:0]      i2c_wr_data2;
  logic [1:0]      i2c_num_rd_bytes;
  logic            i2c_start;
  logic            i2c_done;
  logic [7:0]      i2c_rd_data0;
  logic [7:0]      i2c_rd_data1;
  logic            i2c_rst_req;

  logic [6:0] d_addr [NR];
  logic [1:0] d_nwr  [NR];
  logic [7:0] d_w0   [NR];
  logic [7:0] d_w1   [NR];
  logic [7:0] d_w2   [NR];
  logic [1:0] d_nrd  [NR];

  int checks;
  int errors;
  int model_ptr;

  i2c_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .req_num_wr(req_num_wr), .req_wr_data(req_wr_data), .req_num_rd(req_num_rd),
    .ack(ack), .err(err), .rd_data(rd_data), .busy(busy), .grant_id(grant_id),
    .i2c_addr(i2c_addr), .i2c_num_wr_bytes(i2c_num_wr_bytes),
    .i2c_wr_data0(i2c_wr_data0), .i2c_wr_data1(i2c_wr_data1),
    .i2c_wr_data2(i2c_wr_data2), .i2c_num_rd_bytes(i2c_num_rd_bytes),
    .i2c_start(i2c_start), .i2c_done(i2c_done), .i2c_rd_data0(i2c_rd_data0),
    .i2c_rd_data1(i2c_rd_data1), .i2c_rst_req(i2c_rst_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack per-requester descriptors onto the flat buses.
  always_comb begin
    for (int i = 0; i < int'(NR); i++) begin
      req_addr[7*i +: 7]      = d_addr[i];
      req_num_wr[2*i +: 2]    = d_nwr[i];
      req_wr_data[24*i +: 8]  = d_w0[i];
      req_wr_data[24*i+8 +: 8]  = d_w1[i];
      req_wr_data[24*i+16 +: 8] = d_w2[i];
      req_num_rd[2*i +: 2]    = d_nrd[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester at or after ptr, modulo NR.
  function automatic int exp_grant(input logic [NR-1:0] r, input int p);
    for (int k = 0; k < int'(NR); k++) begin
      if (((r >> ((p + k) % int'(NR))) & NR'(1)) != '0) return (p + k) % int'(NR);
    end
    return 0;
  endfunction

  task automatic rand_desc(input int i);
    d_addr[i] = 7'($urandom);
    d_nwr[i]  = 2'($urandom_range(3));
    d_w0[i]   = 8'($urandom);
    d_w1[i]   = 8'($urandom);
    d_w2[i]   = 8'($urandom);
    d_nrd[i]  = 2'($urandom_range(2));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    check("rst_ack",   32'(ack), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_ctl",   32'({i2c_start, i2c_rst_req, err, grant_id}), 32'h0);
    check("rst_desc",  32'({i2c_addr, i2c_num_wr_bytes, i2c_num_rd_bytes}), 32'h0);
    check("rst_wdata", 32'({i2c_wr_data2, i2c_wr_data1, i2c_wr_data0}), 32'h0);
    check("rst_rd",    32'(rd_data), 32'h0);
    reset = 1'b0;
    model_ptr = 0;
  endtask

  // One complete transaction, called with the DUT idle and req already driven.
  task automatic do_txn(input int unsigned delay, input bit drop, input bit mutate,
                        input logic [6:0] new_addr, input logic [15:0] rdv);
    int g;
    logic [6:0]    s_addr;
    logic [NR-1:0] e_ack;
    g = exp_grant(req, model_ptr);
    tick();
    check("start_early", 32'(i2c_start), 32'h0);
    check("busy_grant",  32'(busy), 32'h1);
    tick();
    check("start",    32'(i2c_start), 32'h1);
    check("grant_id", 32'(grant_id), 32'(g));
    check("desc",     32'({i2c_addr, i2c_num_wr_bytes, i2c_num_rd_bytes}),
                      32'({d_addr[g], d_nwr[g], d_nrd[g]}));
    check("wdata",    32'({i2c_wr_data2, i2c_wr_data1, i2c_wr_data0}),
                      32'({d_w2[g], d_w1[g], d_w0[g]}));
    s_addr = d_addr[g];
    if (mutate) d_addr[g] = new_addr;
    for (int d = 0; d < int'(delay); d++) begin
      tick();
      if (d == 0) check("start_pulse", 32'(i2c_start), 32'h0);
    end
    check("freeze", 32'(i2c_addr), 32'(s_addr));
    i2c_done = 1'b1;
    {i2c_rd_data1, i2c_rd_data0} = rdv;
    tick();
    i2c_done = 1'b0;
    {i2c_rd_data1, i2c_rd_data0} = 16'($urandom);
    e_ack = NR'(1) << g;
    check("ack",     32'(ack), 32'(e_ack));
    check("rd_data", 32'(rd_data), 32'(rdv));
    check("err",     32'({err, i2c_rst_req}), 32'h0);
    check("freeze_ack", 32'(i2c_addr), 32'(s_addr));
    if (drop) req[g] = 1'b0;
    tick();
    check("ack_once",  32'(ack), 32'h0);
    check("busy_hold", 32'(busy), 32'h1);
    tick();
    check("busy_drop", 32'(busy), 32'h0);
    check("rd_held",   32'(rd_data), 32'(rdv));
    model_ptr = (g + 1) % int'(NR);
  endtask

  initial begin
    logic [15:0] held;
    checks = 0;
    errors = 0;
    model_ptr = 0;
    reset = 1'b1;
    req = '0;
    i2c_done = 1'b0;
    i2c_rd_data0 = 8'h00;
    i2c_rd_data1 = 8'h00;
    for (int i = 0; i < int'(NR); i++) rand_desc(i);

    do_reset();

    // Single write transaction from requester 1, long engine latency.
    d_addr[1] = 7'h20; d_nwr[1] = 2'd3; d_w0[1] = 8'h02; d_w1[1] = 8'hAA;
    d_w2[1] = 8'h55; d_nrd[1] = 2'd0;
    req = 4'b0010;
    do_txn(100, 1'b1, 1'b0, 7'h00, 16'($urandom));

    // Read return.
    d_addr[2] = 7'h20; d_nwr[2] = 2'd1; d_nrd[2] = 2'd2;
    req = 4'b0100;
    do_txn(5, 1'b1, 1'b0, 7'h00, 16'h1234);

    // Descriptor freeze: address changes to 0x21 during WAIT.
    d_addr[3] = 7'h20;
    req = 4'b1000;
    do_txn(6, 1'b1, 1'b1, 7'h21, 16'h5A5A);

    // Round-robin under full load, then with a sparser request set.
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) do_txn(2 + n, 1'b0, 1'b0, 7'h00, 16'($urandom));
    req = 4'b1010;
    for (int n = 0; n < 3; n++) do_txn(3, 1'b0, 1'b0, 7'h00, 16'($urandom));
    req = '0;

    // Engine done while idle must be ignored.
    held = rd_data;
    i2c_done = 1'b1;
    {i2c_rd_data1, i2c_rd_data0} = ~held;
    tick();
    i2c_done = 1'b0;
    tick();
    check("idle_done_busy", 32'(busy), 32'h0);
    check("idle_done_ack",  32'(ack), 32'h0);
    check("idle_done_rd",   32'(rd_data), 32'(held));

    // Engine never completes.
    do_reset();
    held = rd_data;
    req = 4'b0001;
    tick();
    tick();
    check("to_start", 32'(i2c_start), 32'h1);
`ifdef I2C_ARB_TIMEOUT_EN
    tick();
    for (int k = 0; k < int'(TO) - 1; k++) tick();
    check("to_not_early", 32'({ack, i2c_rst_req}), 32'h0);
    tick();
    check("to_ack", 32'(ack), 32'h1);
    check("to_err", 32'({err, i2c_rst_req}), 32'h3);
    check("to_rd",  32'(rd_data), 32'(held));
    req = '0;
    tick();
    check("to_rst_pulse", 32'(i2c_rst_req), 32'h0);
    tick();
    check("to_busy_drop", 32'(busy), 32'h0);
    model_ptr = 1;
`else
    for (int k = 0; k < 40; k++) tick();
    check("hang_busy", 32'(busy), 32'h1);
    check("hang_outs", 32'({ack, err, i2c_rst_req}), 32'h0);
    req = '0;
    do_reset();
`endif

    // Reset while waiting on the engine: no ack, pending request regranted.
    req = 4'b0100;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midwait_ack",  32'(ack), 32'h0);
    check("midwait_busy", 32'(busy), 32'h0);
    check("midwait_ctl",  32'({i2c_start, grant_id, i2c_addr}), 32'h0);
    check("midwait_rd",   32'(rd_data), 32'h0);
    reset = 1'b0;
    model_ptr = 0;
    do_txn(4, 1'b1, 1'b0, 7'h00, 16'($urandom));

    // Pointer returns to 0 on reset.
    req = 4'b0001;
    do_txn(2, 1'b1, 1'b0, 7'h00, 16'($urandom));
    do_reset();
    req = 4'b0011;
    do_txn(2, 1'b1, 1'b0, 7'h00, 16'($urandom));

    // Randomized transactions.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < int'(NR); i++) begin
        if ($urandom_range(1) == 1) rand_desc(i);
      end
      if (req == '0 || $urandom_range(3) == 0) req = NR'($urandom_range(15, 1));
      do_txn($urandom_range(8, 1), 1'($urandom_range(1)), 1'($urandom_range(1)),
             7'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
